load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 16 +
 rtl/lsu_align.sv | 33 +++
 rtl/load_store_unit.sv | 90 +++++++++
 tb/tb_load_store_unit.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared width constants, funct3 codes and FSM states for the load/store unit.
package lsu_pkg;
    localparam int XLEN = 32;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_READ,
        S_WRITE,
        S_DONE
    } state_e;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: little-endian lane extract/extend for loads and lane merge for stores.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      off_i,
    input  logic [XLEN-1:0] rd_word_i,
    input  logic [XLEN-1:0] old_word_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] ld_word_o,
    output logic [XLEN-1:0] st_word_o
);
    logic [7:0]  b;
    logic [15:0] h;

    assign b = rd_word_i[{off_i, 3'b000} +: 8];
    assign h = off_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];

    assign ld_word_o = (funct3_i == F3_B)  ? {{24{b[7]}}, b}  :
                       (funct3_i == F3_BU) ? {24'b0, b}       :
                       (funct3_i == F3_H)  ? {{16{h[15]}}, h} :
                       (funct3_i == F3_HU) ? {16'b0, h}       : rd_word_i;

    always_comb begin
        st_word_o = old_word_i;
        if (funct3_i == F3_B)
            st_word_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
        else if (funct3_i == F3_H)
            st_word_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
        else
            st_word_o = wdata_i;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I byte/half/word loads and stores against a single-port word memory,
// with read-modify-write for sub-word stores and up-front alignment/range checking.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req,
    input  logic            is_store,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_we,
    input  logic [XLEN-1:0] mem_rdata
);
    state_e          state_q, state_d;
    logic            is_store_q, err_q, bad, legal;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] addr_q, wdata_q, rmw_q, rdata_q, ld_word, st_word;

    assign legal = is_store ? (funct3 inside {F3_B, F3_H, F3_W})
                            : (funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    assign bad = !legal
               || ((funct3 == F3_H || funct3 == F3_HU) && addr[0])
               || (funct3 == F3_W && addr[1:0] != 2'b00)
               || (addr > 32'(MEM_BYTES - 4));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (req) state_d = bad ? S_DONE : !is_store ? S_LOAD :
                                           (funct3 == F3_W) ? S_WRITE : S_RMW_READ;
            S_LOAD:     state_d = S_DONE;
            S_RMW_READ: state_d = S_WRITE;
            S_WRITE:    state_d = S_DONE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            is_store_q <= 1'b0;
            err_q      <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rmw_q      <= '0;
            rdata_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && req) begin
                is_store_q <= is_store;
                err_q      <= bad;
                funct3_q   <= funct3;
                addr_q     <= addr;
                wdata_q    <= wdata;
            end
            if (state_q == S_LOAD) rdata_q <= ld_word;
            if (state_q == S_RMW_READ) rmw_q <= mem_rdata;
        end
    end

    lsu_align u_align (
        .funct3_i  (funct3_q),
        .off_i     (addr_q[1:0]),
        .rd_word_i (mem_rdata),
        .old_word_i(rmw_q),
        .wdata_i   (wdata_q),
        .ld_word_o (ld_word),
        .st_word_o (st_word)
    );

    // Memory-facing outputs are pure state decodes so reset silences them immediately.
    assign busy      = state_q != S_IDLE;
    assign done      = state_q == S_DONE;
    assign err       = done && err_q;
    assign rdata     = rdata_q;
    assign mem_we    = state_q == S_WRITE;
    assign mem_addr  = (state_q inside {S_LOAD, S_RMW_READ, S_WRITE}) ? {addr_q[31:2], 2'b00} : '0;
    assign mem_wdata = mem_we ? st_word : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized accesses checked cycle by cycle against a byte-array memory model.
module tb_load_store_unit;
    logic        clk = 0, rst = 1, req = 0, is_store = 0;
    logic [2:0]  funct3 = 0;
    logic [31:0] addr = 0, wdata = 0;
    logic        busy, done, err, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [31:0] mem [0:63];
    logic [7:0]  rm [0:255];
    logic [31:0] exp_rdata = 0, last_we_addr = 0, last_we_data = 0;
    int          checks = 0, errors = 0, done_cnt = 0, we_cnt = 0;

    load_store_unit #(.MEM_BYTES(256)) dut (
        .clk(clk), .rst(rst), .req(req), .is_store(is_store), .funct3(funct3),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
        .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
            last_we_addr <= mem_addr;
            last_we_data <= mem_wdata;
            we_cnt <= we_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Starts at a negedge with the DUT idle; returns at the negedge of the following idle cycle.
    task automatic access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input bit hold);
        int sz, lat;
        bit legal, bad;
        logic [31:0] v, ew, wa;
        sz    = (f3[1:0] == 0) ? 1 : (f3[1:0] == 1) ? 2 : 4;
        legal = st ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
        bad   = !legal || (a % sz) != 0 || a > 252;
        lat   = bad ? 1 : (!st || sz == 4) ? 2 : 3;
        wa    = {a[31:2], 2'b00};
        v     = 0;
        ew    = 0;
        if (!bad && !st) begin
            for (int i = 0; i < sz; i++) v = v | (32'(rm[a + i]) << (8 * i));
            if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | (32'hFFFFFFFF << (8 * sz));
        end
        if (!bad && st) begin
            for (int i = 0; i < sz; i++) rm[a + i] = wd[8 * i +: 8];
            ew = {rm[wa + 3], rm[wa + 2], rm[wa + 1], rm[wa]};
        end
        req = 1; is_store = st; funct3 = f3; addr = a; wdata = wd;
        for (int n = 1; n <= lat; n++) begin
            @(negedge clk);
            if (!hold) req = 0;
            chk("busy", busy, 1);
            chk("done", done, 32'(n == lat));
            chk("err", err, 32'(n == lat && bad));
            chk("mem_we", mem_we, 32'(!bad && st && n == lat - 1));
            if (n < lat) chk("mem_addr", mem_addr, wa);
            if (mem_we) chk("mem_wdata", mem_wdata, ew);
        end
        if (!bad && !st) exp_rdata = v;
        chk("rdata", rdata, exp_rdata);
        @(negedge clk);
        chk("idle busy", busy, 0);
        chk("idle done", done, 0);
        chk("idle mem_addr", mem_addr, 0);
        chk("idle mem_we", mem_we, 0);
    endtask

    initial begin
        int t, d;
        logic [31:0] w, old, a;
        logic [2:0] f3;
        for (int i = 0; i < 64; i++) begin
            w = (i == 4) ? 32'h8899AABB : $urandom;
            mem[i] = w;
            for (int j = 0; j < 4; j++) rm[4 * i + j] = w[8 * j +: 8];
        end
        #12;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        chk("rst rdata", rdata, 0);
        chk("rst mem_we", mem_we, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        @(negedge clk); rst = 0;
        @(negedge clk);

        access(0, 3'b000, 32'h11, 0, 0); chk("lb lit", rdata, 32'hFFFFFFAA);
        access(0, 3'b100, 32'h11, 0, 0); chk("lbu lit", rdata, 32'h000000AA);
        access(0, 3'b001, 32'h12, 0, 0); chk("lh lit", rdata, 32'hFFFF8899);
        access(0, 3'b101, 32'h12, 0, 0); chk("lhu lit", rdata, 32'h00008899);
        access(0, 3'b010, 32'h10, 0, 0); chk("lw lit", rdata, 32'h8899AABB);
        t = we_cnt;
        access(1, 3'b000, 32'h13, 32'h12345677, 0);
        chk("sb we count", we_cnt - t, 1);
        chk("sb we addr", last_we_addr, 32'h10);
        chk("sb we data", last_we_data, 32'h7799AABB);
        t = we_cnt;
        access(1, 3'b001, 32'h11, 32'h5555, 0);
        access(0, 3'b010, 32'h0E, 0, 0);
        access(1, 3'b010, 32'h100, 32'h1, 0);
        access(1, 3'b100, 32'h20, 32'h1, 0);
        chk("err no writes", we_cnt - t, 0);
        chk("err rdata held", rdata, 32'h8899AABB);

        old = mem[8];
        d = done_cnt;
        req = 1; is_store = 1; funct3 = 3'b010; addr = 32'h20; wdata = 32'hDEADBEEF;
        @(posedge clk); #1 req = 0;
        #1 rst = 1;
        #1;
        chk("abort busy", busy, 0);
        chk("abort mem_we", mem_we, 0);
        @(posedge clk);
        @(negedge clk); rst = 0;
        chk("abort word", mem[8], old);
        chk("abort no done", done_cnt - d, 0);
        exp_rdata = 0;
        chk("abort rdata", rdata, 0);
        @(negedge clk);

        d = done_cnt;
        for (int k = 0; k < 6; k++) begin
            f3 = (k % 3 == 0) ? 3'b010 : (k % 3 == 1) ? 3'b001 : 3'b000;
            a = $urandom_range(0, 63) * 4 + ((f3 == 3'b000) ? 32'($urandom_range(0, 3)) :
                                             (f3 == 3'b001) ? 32'(2) : 32'(0));
            access(k[0], f3, a, $urandom, 1);
        end
        req = 0;
        chk("held req dones", done_cnt - d, 6);

        for (int k = 0; k < 250; k++) begin
            f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) :
                 3'($urandom_range(0, 4) < 3 ? $urandom_range(0, 2) : $urandom_range(4, 5));
            a = $urandom_range(0, 300);
            if ($urandom_range(0, 3) != 0) a = f3[1] ? (a & ~32'd3) : f3[0] ? (a & ~32'd1) : a;
            access(1'($urandom_range(0, 1)), f3, a, $urandom, 1'($urandom_range(0, 1)));
        end
        req = 0;
        @(negedge clk);
        for (int i = 0; i < 64; i++)
            chk("final mem", mem[i], {rm[4 * i + 3], rm[4 * i + 2], rm[4 * i + 1], rm[4 * i]});
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
